// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester
// select encoding and the default word-address width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic SEL_P = 1'b0;
  localparam logic SEL_L = 1'b1;

  localparam int DEFAULT_AW = 10;

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner select for the data-memory arbiter: pipeline first, loader when it is
// the only requester or once the pipeline has used up its run allowance.
module dmem_arb_prio
  import mips_mem_pkg::*;
#(
  parameter int MAX_P_RUN = 4
) (
  input  logic       p_req,
  input  logic       l_req,
  input  logic [3:0] p_run_cnt,
  output logic       grant,
  output logic       sel
);

  logic starved;

  always_comb begin
    starved = (p_run_cnt == 4'(MAX_P_RUN));
    grant   = p_req | l_req;
    sel     = SEL_P;
    if (l_req && (!p_req || starved)) begin
      sel = SEL_L;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: pipeline MEM stage
// versus loader, one access at a time through IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int MAX_P_RUN   = 4,
  parameter int AW          = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [31:0]   p_wdata,
  output logic          p_ack,
  output logic [31:0]   p_rdata,
  output logic          p_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ack,
  output logic [31:0]   l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  arb_state_e    state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    p_run_cnt_q, p_run_cnt_d;
  logic          sel_q, sel_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   p_rdata_q, p_rdata_d;
  logic [31:0]   l_rdata_q, l_rdata_d;

  logic          arb_grant;
  logic          arb_sel;
  logic          in_resp;

  dmem_arb_prio #(
    .MAX_P_RUN(MAX_P_RUN)
  ) u_prio (
    .p_req    (p_req),
    .l_req    (l_req),
    .p_run_cnt(p_run_cnt_q),
    .grant    (arb_grant),
    .sel      (arb_sel)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    p_run_cnt_d = p_run_cnt_q;
    sel_d       = sel_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p_rdata_d   = p_rdata_q;
    l_rdata_d   = l_rdata_q;

    unique case (state_q)
      IDLE: begin
        // The run count only matters while the loader is actually waiting.
        if (!l_req) begin
          p_run_cnt_d = '0;
        end
        if (arb_grant) begin
          sel_d      = arb_sel;
          mem_en_d   = 1'b1;
          wait_cnt_d = 3'(WAIT_CYCLES);
          state_d    = ACCESS;
          if (arb_sel == SEL_L) begin
            mem_we_d    = l_we;
            mem_addr_d  = l_addr;
            mem_wdata_d = l_wdata;
            p_run_cnt_d = '0;
          end else begin
            mem_we_d    = p_we;
            mem_addr_d  = p_addr;
            mem_wdata_d = p_wdata;
            if (l_req && (p_run_cnt_q != 4'(MAX_P_RUN))) begin
              p_run_cnt_d = p_run_cnt_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (sel_q == SEL_P) begin
          p_rdata_d = mem_rdata;
        end else begin
          l_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      p_run_cnt_q <= '0;
      sel_q       <= SEL_P;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p_rdata_q   <= '0;
      l_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      p_run_cnt_q <= p_run_cnt_d;
      sel_q       <= sel_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p_rdata_q   <= p_rdata_d;
      l_rdata_q   <= l_rdata_d;
    end
  end

  // Read data passes straight through during the ack cycle, then holds.
  assign in_resp   = (state_q == RESP);
  assign p_ack     = in_resp && (sel_q == SEL_P);
  assign l_ack     = in_resp && (sel_q == SEL_L);
  assign p_rdata   = p_ack ? mem_rdata : p_rdata_q;
  assign l_rdata   = l_ack ? mem_rdata : l_rdata_q;
  assign p_stall   = p_req & ~p_ack;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between two requesters: the pipeline MEM stage (loads/stores) and the program/data loader port used for memory initialisation and debug readback. It sequences each access through a small FSM with programmable wait states and generates the pipeline stall. It sits between the MEM-stage logic and the data memory instance, replacing the direct MEM-stage-to-memory connection.

## Interface
- `WAIT_CYCLES`, 0: extra memory cycles per access beyond the first (0..7).
- `MAX_P_RUN`, 4: consecutive pipeline grants allowed while a loader request is pending (1..15).
- `AW`, 10: word address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `p_req` input 1: pipeline access request; held until `p_ack`.
- `p_we` input 1: pipeline write (1) or read (0).
- `p_addr` input AW: pipeline address.
- `p_wdata` input 32: pipeline store data.
- `p_ack` output 1: one-cycle completion pulse to the pipeline.
- `p_rdata` output 32: pipeline load data, valid while `p_ack`=1.
- `p_stall` output 1: `p_req & ~p_ack`, combinational.
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_ack`, `l_rdata`: loader port, same widths and rules as the pipeline port.
- `mem_en` output 1: memory access enable (registered).
- `mem_we` output 1: memory write enable (registered).
- `mem_addr` output AW: memory address (registered).
- `mem_wdata` output 32: memory write data (registered).
- `mem_rdata` input 32: memory read data, valid in the cycle after the last ACCESS cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is present, select a winner and latch `we/addr/wdata` into the `mem_*` registers with `mem_en`=1; go to ACCESS with `wait_cnt`=WAIT_CYCLES.
- ACCESS: if `wait_cnt`≠0, decrement and stay; at 0, go to RESP and drop `mem_en`/`mem_we` on that edge.
- RESP: assert the winner's `*_ack`, drive the winner's `*_rdata` from `mem_rdata`, then return to IDLE. Writes also ack; rdata is don't-care for writes.
- Arbitration (IDLE only): the pipeline wins by default. If `l_req` is present and `p_run_cnt`=MAX_P_RUN, the loader wins.
- `p_run_cnt` increments on each pipeline grant made while `l_req`=1. It clears on a loader grant or when `l_req`=0 in IDLE, and saturates at MAX_P_RUN.
- Outside RESP, `p_rdata`/`l_rdata` hold the last value returned to that port (per-port capture register loaded in RESP).
- The loser's request stays pending; no request is lost or merged.
- Requests dropped before ack are illegal; behaviour is undefined and covered by a bench assertion.

## Timing
- Reset values:
  - state=IDLE, `wait_cnt`=0, `p_run_cnt`=0.
  - `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `p_ack`=`l_ack`=0, `p_rdata`=`l_rdata`=0.
  - `p_stall` follows `p_req`.
- Latency from request seen in IDLE (cycle 0) to ack: 2+WAIT_CYCLES cycles. `mem_en` is high for cycles 1..1+WAIT_CYCLES.
- Throughput: one access per 3+WAIT_CYCLES cycles. IDLE is always visited between accesses.
- A requester may hold `*_req` high through ack for a new access. In the IDLE cycle after RESP that request is re-arbitrated as a fresh one.
- Simultaneous `p_req` and `l_req` in IDLE: the pipeline wins unless the starvation limit has been hit.
- Asynchronous reset mid-ACCESS: `mem_en`/`mem_we` drop immediately, the access is aborted (a write may be partial), and no ack is issued.

## Structure
- Shared package `mips_mem_pkg`:
  - FSM state enum (IDLE/ACCESS/RESP).
  - Port-select constants (SEL_P, SEL_L).
  - Default `AW`.
- Sub-module `dmem_arb_prio`: combinational winner select from `p_req`, `l_req`, `p_run_cnt`, MAX_P_RUN.
- FSM, counters and `mem_*` registers stay in `dmem_arbiter`.

## Test plan
- WAIT_CYCLES=0: pipeline write `p_addr`=0x019, `p_wdata`=0x01354440, then read 0x019 → `p_ack` at cycle 2 of each access, read returns 0x01354440; `p_stall`=1 for exactly 2 cycles per access.
- WAIT_CYCLES=3: single pipeline read → `mem_en` high for 4 cycles, `p_ack` at cycle 5, `p_stall` high for 5 cycles.
- `p_req` and `l_req` both held continuously, MAX_P_RUN=4 → grant sequence P,P,P,P,L repeating; `l_ack` never more than 5 accesses apart.
- Loader writes 0xDEADBEEF to 0x3FF, pipeline then reads 0x3FF → `p_rdata`=0xDEADBEEF; `l_rdata` unchanged by the pipeline ack.
- `rst_n` pulsed low during ACCESS of a write with WAIT_CYCLES=2 → `mem_we` low in the same cycle, no ack, state IDLE; next request completes normally.
- Back-to-back: `p_req` held high across ack → second access starts with IDLE for one cycle, ack 3+WAIT_CYCLES cycles after the first.
